sparc_muldiv_seq: RTL
=====================

Name: sparc_muldiv_seq

Overview:
Iterative multiply/divide sequencer for the integer execute stage. It implements UMUL, SMUL, UDIV and SDIV (plus their cc forms) over multiple cycles, so the single-cycle ALU datapath never carries a 32x32 multiplier or 64/32 divider. Decode issues an op with a start pulse, and the pipeline stalls while busy is high. On completion the block returns the result, the Y update and the icc update with one-cycle write strobes.

Parameters:
WIDTH, 32, operand/result width; Y and dividend-high are also WIDTH.
MUL_ITERS, 32, radix-2 multiply iterations (equals WIDTH).
DIV_ITERS, 64, radix-2 restoring-divide iterations over the 2*WIDTH dividend.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  op request; sampled only in IDLE
op  in  2  0=UMUL 1=SMUL 2=UDIV 3=SDIV
set_cc  in  1  cc form of op; enables icc_we at completion
rs1  in  32  multiplicand / dividend low word
rs2  in  32  multiplier / divisor (already muxed with simm13)
y_in  in  32  Y register; dividend high word for divide
flush  in  1  kill in-flight op (trap/mispredict)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
result  out  32  rd value; held until the next done
y_out  out  32  multiply high word; held
y_we  out  1  pulse with done on multiply only
icc_out  out  4  {n,z,v,c}; held
icc_we  out  1  pulse with done when set_cc=1 and div_zero=0
div_zero  out  1  pulse with done when divide and rs2==0

Behaviour:
- Reset is asynchronous. Every output and internal register goes to 0, and the state goes to IDLE.
- States are IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch op, set_cc, rs1, rs2, y_in, then go to PREP. busy rises at the next edge.
  - start while not in IDLE is ignored; decode must hold the request while busy.
- PREP (1 cycle):
  - Signed ops: take magnitudes of operands and record the result sign (sign(a) XOR sign(b)). For SDIV the dividend sign is bit 63 of {y_in,rs1}.
  - Divide with rs2==0: go to DONE with div_zero set, result 0, no icc/Y write.
  - Otherwise load the counter with MUL_ITERS or DIV_ITERS and go to ITER.
- ITER:
  - One shift-add (multiply) or shift-subtract (restoring divide) step per cycle.
  - The counter decrements; at count==1 go to FIX.
  - Divide produces a 64-bit unsigned quotient magnitude.
- FIX (1 cycle):
  - Apply the sign (two's complement negate) to the 64-bit product or quotient.
  - UMUL/SMUL: result=prod[31:0], y_out=prod[63:32], icc={prod[31], prod[31:0]==0, 0, 0}.
  - UDIV: if q[63:32]!=0, result=32'hFFFFFFFF and v=1; else result=q[31:0] and v=0.
  - SDIV: if the true quotient > 2^31-1, result=32'h7FFFFFFF and v=1; if < -2^31, result=32'h80000000 and v=1. Otherwise result=q[31:0] and v=0. Quotient truncates toward zero.
  - Divide icc={result[31], result==0, v, 0}. The remainder is discarded and Y is not written.
- DONE (1 cycle):
  - done=1; y_we and icc_we assert per the port rules.
  - busy=0 in this cycle; the next state is IDLE. Start is accepted again from the following cycle.
- Latency from the start edge to the done cycle: multiply 35 cycles (1+32+1+1), divide 67, divide-by-zero 2.
- flush:
  - In any non-IDLE state, go to IDLE at the next edge.
  - No done and no write strobes are produced; result, y_out and icc_out keep their prior values.
  - flush has priority over start and over completion in the same cycle.
- Strobes (done, y_we, icc_we, div_zero) are never high outside DONE.
- Arithmetic is unsigned internally. The product register is 64b, the partial remainder 33b and the quotient 64b, with no truncation before FIX.

Test Plan:
- UMUL: rs1=rs2=32'hFFFFFFFF, set_cc=1 -> done 35 cycles after start; result=32'h00000001, y_out=32'hFFFFFFFE, y_we=1, icc_out=4'b0000, busy high for 34 cycles.
- SMUL: rs1=-3, rs2=5, set_cc=1 -> result=32'hFFFFFFF1, y_out=32'hFFFFFFFF, icc_out=4'b1000.
- UDIV:
  - y_in=1, rs1=0, rs2=2 -> result=32'h80000000, v=0, done at cycle 67, y_we=0.
  - y_in=2, rs1=0, rs2=2, set_cc=1 -> result=32'hFFFFFFFF, icc_out=4'b1010.
- SDIV:
  - y_in=32'hFFFFFFFF, rs1=32'hFFFFFFF9, rs2=2 -> result=32'hFFFFFFFD.
  - y_in=0, rs1=32'h80000000, rs2=1, set_cc=1 -> result=32'h7FFFFFFF, icc_out=4'b0010.
- Divide by zero: UDIV with rs2=0 -> done 2 cycles after start, div_zero=1, result=0, icc_we=0.
- flush at ITER cycle 10 -> busy low next cycle, no done/strobes in the next 70 cycles, outputs unchanged. A following UMUL 7*6 gives result=42 at 35 cycles. Asserting reset mid-ITER zeroes all outputs immediately.

Source files
------------

// File: rtl/sparc_muldiv_seq.sv
// Iterative SPARC multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// with sign fix-up, divide saturation, and one-cycle Y/icc write strobes on completion.
module sparc_muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter int MUL_ITERS = 32,
  parameter int DIV_ITERS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] y_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y_out,
  output logic             y_we,
  output logic [3:0]       icc_out,
  output logic             icc_we,
  output logic             div_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DIV_ITERS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v, input logic n);
    return n ? ((~v) + {{(DW-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             set_cc_q, set_cc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] y_out_q, y_out_d;
  logic             y_we_q, y_we_d;
  logic [3:0]       icc_q, icc_d;
  logic             icc_we_q, icc_we_d;
  logic             div_zero_q, div_zero_d;

  logic             is_div_s, is_sgn_s;
  logic             a_neg_s, b_neg_s, dvd_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [DW-1:0]    dvd_mag_s;
  logic [WIDTH:0]   mul_sum_s, rem_sh_s, rem_sub_s;
  logic [DW-1:0]    fix_s;
  logic [WIDTH-1:0] div_res_s;
  logic             div_v_s;

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign y_out    = y_out_q;
  assign y_we     = y_we_q;
  assign icc_out  = icc_q;
  assign icc_we   = icc_we_q;
  assign div_zero = div_zero_q;

  // Next-state, datapath step and completion values.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    set_cc_d   = set_cc_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    result_d   = result_q;
    y_out_d    = y_out_q;
    icc_d      = icc_q;
    done_d     = 1'b0;
    y_we_d     = 1'b0;
    icc_we_d   = 1'b0;
    div_zero_d = 1'b0;

    is_div_s  = op_q[1];
    is_sgn_s  = op_q[0];
    a_neg_s   = is_sgn_s & a_q[WIDTH-1];
    b_neg_s   = is_sgn_s & b_q[WIDTH-1];
    dvd_neg_s = is_sgn_s & y_q[WIDTH-1];
    a_mag_s   = neg_w(a_q, a_neg_s);
    b_mag_s   = neg_w(b_q, b_neg_s);
    dvd_mag_s = neg_dw({y_q, a_q}, dvd_neg_s);
    mul_sum_s = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, a_q};
    rem_sh_s  = {rem_q[WIDTH-1:0], acc_q[DW-1]};
    rem_sub_s = rem_sh_s - {1'b0, b_q};
    fix_s     = neg_dw(acc_q, neg_q);

    // Saturation works on the unsigned quotient magnitude held in acc_q.
    if (!is_sgn_s) begin
      if (|acc_q[DW-1:WIDTH]) begin
        div_res_s = {WIDTH{1'b1}};
        div_v_s   = 1'b1;
      end else begin
        div_res_s = acc_q[WIDTH-1:0];
        div_v_s   = 1'b0;
      end
    end else if (!neg_q && (|acc_q[DW-1:WIDTH-1])) begin
      div_res_s = {1'b0, {(WIDTH-1){1'b1}}};
      div_v_s   = 1'b1;
    end else if (neg_q && ((|acc_q[DW-1:WIDTH]) || (acc_q[WIDTH-1] && (|acc_q[WIDTH-2:0])))) begin
      div_res_s = {1'b1, {(WIDTH-1){1'b0}}};
      div_v_s   = 1'b1;
    end else begin
      div_res_s = fix_s[WIDTH-1:0];
      div_v_s   = 1'b0;
    end

    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_d     = op;
            set_cc_d = set_cc;
            a_d      = rs1;
            b_d      = rs2;
            y_d      = y_in;
            state_d  = S_PREP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PREP: begin
          if (is_div_s && (b_q == {WIDTH{1'b0}})) begin
            result_d   = {WIDTH{1'b0}};
            done_d     = 1'b1;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else if (is_div_s) begin
            acc_d   = dvd_mag_s;
            rem_d   = {(WIDTH+1){1'b0}};
            b_d     = b_mag_s;
            neg_d   = dvd_neg_s ^ b_neg_s;
            cnt_d   = CW'(DIV_ITERS);
            state_d = S_ITER;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_mag_s};
            a_d     = a_mag_s;
            neg_d   = a_neg_s ^ b_neg_s;
            cnt_d   = CW'(MUL_ITERS);
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          if (is_div_s) begin
            if (!rem_sub_s[WIDTH]) begin
              rem_d = rem_sub_s;
              acc_d = {acc_q[DW-2:0], 1'b1};
            end else begin
              rem_d = rem_sh_s;
              acc_d = {acc_q[DW-2:0], 1'b0};
            end
          end else begin
            if (acc_q[0]) begin
              acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
            end else begin
              acc_d = {1'b0, acc_q[DW-1:1]};
            end
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
        end
        S_FIX: begin
          if (is_div_s) begin
            result_d = div_res_s;
            icc_d    = {div_res_s[WIDTH-1], (div_res_s == {WIDTH{1'b0}}), div_v_s, 1'b0};
          end else begin
            result_d = fix_s[WIDTH-1:0];
            y_out_d  = fix_s[DW-1:WIDTH];
            y_we_d   = 1'b1;
            icc_d    = {fix_s[WIDTH-1], (fix_s[WIDTH-1:0] == {WIDTH{1'b0}}), 2'b00};
          end
          done_d   = 1'b1;
          icc_we_d = set_cc_q;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIX);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      set_cc_q   <= 1'b0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      y_q        <= {WIDTH{1'b0}};
      neg_q      <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {DW{1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= {WIDTH{1'b0}};
      y_out_q    <= {WIDTH{1'b0}};
      y_we_q     <= 1'b0;
      icc_q      <= 4'b0000;
      icc_we_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      set_cc_q   <= set_cc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      y_q        <= y_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      y_out_q    <= y_out_d;
      y_we_q     <= y_we_d;
      icc_q      <= icc_d;
      icc_we_q   <= icc_we_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule
